// File: rtl/fpu_issue_arbiter.sv
// Round-robin front end sharing one FPU among NREQ requesters: one op in flight,
// one-hot opcode pulse, tagged response with valid/ready, watchdog for a hung FPU.
module fpu_issue_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][3:0]  req_op,
  input  logic [NREQ-1:0][31:0] req_x1,
  input  logic [NREQ-1:0][31:0] req_x2,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [31:0]           resp_y,
  output logic                  resp_ovf,
  output logic                  resp_unf,
  output logic                  resp_err,
  output logic                  fpu_rstn,
  output logic [9:0]            fpu_opcode,
  output logic [31:0]           fpu_x1,
  output logic [31:0]           fpu_x2,
  input  logic [31:0]           fpu_y,
  input  logic                  fpu_ovf,
  input  logic                  fpu_unf,
  input  logic                  fpu_valid,
  output logic                  busy
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef struct packed { logic [3:0] op; logic [31:0] x1; logic [31:0] x2; } req_t;
  typedef struct packed { logic [31:0] y; logic ovf; logic unf; logic err; } resp_t;

  state_t        state, nxt;
  logic [PW-1:0] ptr, gnt_idx, scan_idx, cur_g;
  logic          gnt_found, accept, wd_fire, rst_d, op_active;
  logic [CW-1:0] cnt;
  req_t          cur, gnt_req;
  resp_t         rsp;

  // Scan from the highest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(ptr) + k) % NREQ);
      if (req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign gnt_req = {req_op[gnt_idx], req_x1[gnt_idx], req_x2[gnt_idx]};
  assign accept  = (state == IDLE) && gnt_found;

  always_comb begin
    nxt     = state;
    wd_fire = 1'b0;
    case (state)
      IDLE:  if (gnt_found) nxt = (gnt_req.op > 4'd9) ? RESP : ISSUE;
      ISSUE: nxt = fpu_valid ? RESP : WAIT;
      WAIT: begin
        if (fpu_valid) nxt = RESP;
        else if (cnt == CNT_LAST) begin
          nxt     = RESP;
          wd_fire = 1'b1;
        end
      end
      RESP:  if (resp_ready[cur_g]) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    rst_d <= rst;
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      cur   <= '0;
      cur_g <= '0;
      rsp   <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (gnt_found) begin
          cur   <= gnt_req;
          cur_g <= gnt_idx;
          ptr   <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
          if (gnt_req.op > 4'd9) rsp <= '{y: '0, ovf: 1'b0, unf: 1'b0, err: 1'b1};
        end
        ISSUE: if (fpu_valid) rsp <= '{y: fpu_y, ovf: fpu_ovf, unf: fpu_unf, err: 1'b0};
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (fpu_valid)    rsp <= '{y: fpu_y, ovf: fpu_ovf, unf: fpu_unf, err: 1'b0};
          else if (wd_fire) rsp <= '{y: '0, ovf: 1'b0, unf: 1'b0, err: 1'b1};
        end
        RESP: if (resp_ready[cur_g]) cnt <= '0;
        default: ;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign req_ready[i]  = accept && (gnt_idx == PW'(i));
      assign resp_valid[i] = (state == RESP) && (cur_g == PW'(i));
    end
  endgenerate

  // Operands are only presented while the FPU owns the op; illegal ops never reach it.
  assign op_active  = (state == ISSUE) || (state == WAIT);
  assign fpu_opcode = (state == ISSUE) ? (10'd1 << cur.op) : '0;
  assign fpu_x1     = op_active ? cur.x1 : '0;
  assign fpu_x2     = op_active ? cur.x2 : '0;
  assign fpu_rstn   = ~(rst | rst_d | wd_fire);
  assign resp_y     = rsp.y;
  assign resp_ovf   = rsp.ovf;
  assign resp_unf   = rsp.unf;
  assign resp_err   = rsp.err;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Randomized directed bench for fpu_issue_arbiter: a behavioural FPU plus a
// transaction-level reference (grant order, cycle timing, expected response).
module tb_fpu_issue_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  logic                  sys_clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [NREQ-1:0][3:0]  req_op = '0;
  logic [NREQ-1:0][31:0] req_x1 = '0, req_x2 = '0;
  logic [31:0]           resp_y, fpu_x1, fpu_x2, fpu_y = '0;
  logic                  resp_ovf, resp_unf, resp_err, fpu_rstn, busy;
  logic                  fpu_ovf = 1'b0, fpu_unf = 1'b0, fpu_valid = 1'b0;
  logic [9:0]            fpu_opcode;

  fpu_issue_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x1(req_x1), .req_x2(req_x2), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_y(resp_y), .resp_ovf(resp_ovf), .resp_unf(resp_unf),
    .resp_err(resp_err), .fpu_rstn(fpu_rstn), .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1),
    .fpu_x2(fpu_x2), .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
    .fpu_valid(fpu_valid), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // stimulus knobs (lat_mode: >0 fixed, -1 never, -2 random incl. never, else random 1..6)
  int              p_req = 0, p_rdy = 0, p_stray = 0, op_mode = 0, fix_op = 0, lat_mode = -3;
  logic [NREQ-1:0] req_mask = '0;
  bit              fix_en = 0, fix_y_en = 0, stray_now = 0, rst_k = 1, log_en = 0;
  logic [31:0]     fix_x1 = '0, fix_x2 = '0, fix_y = '0;

  // reference model state
  int          cyc = 0, vectors = 0, miscompares = 0, fcnt = 0;
  int          n_pulses = 0, n_rstn_low = 0, n_hs = 0;
  int          m_ptr = 0, m_g = 0, m_acc = 0, m_resp_at = -1;
  bit          m_inflight = 0, m_resp = 0, m_rst_d = 0, prev_rstn = 1;
  logic [3:0]  m_op = '0;
  logic [31:0] m_x1 = '0, m_x2 = '0, e_y = '0, last_y = '0;
  logic        e_ovf = 0, e_unf = 0, e_err = 0, last_err = 0;
  logic [NREQ-1:0] rr_log[$];
  int          n0, hs0, low0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(int ptr, logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic int pick_lat();
    if (lat_mode > 0) return lat_mode;
    if (lat_mode == -1) return 0;
    if (lat_mode == -2 && $urandom_range(9) == 0) return 0;
    return int'($urandom_range(6, 1));
  endfunction

  function automatic logic [3:0] pick_op();
    case (op_mode)
      0:       return 4'($urandom_range(9));
      1:       return 4'($urandom_range(15));
      default: return 4'(fix_op);
    endcase
  endfunction

  task automatic check();
    logic [NREQ-1:0] exp_rr, exp_rv;
    logic [9:0]      exp_op;
    logic            exp_rstn;
    int              g;
    bit              in_fpu;
    if (rst) begin
      chk("rstn_in_rst", 32'(fpu_rstn), 32'd0);
      m_inflight = 0; m_resp = 0; m_ptr = 0; m_rst_d = 1; prev_rstn = fpu_rstn;
      return;
    end
    exp_rstn = !m_rst_d;
    m_rst_d  = 0;
    if (m_inflight && !m_resp && cyc == m_resp_at) m_resp = 1;
    in_fpu = m_inflight && !m_resp && m_resp_at < 0 && cyc >= m_acc + 1;
    if (in_fpu) begin
      if (fpu_valid) begin
        e_y = fpu_y; e_ovf = fpu_ovf; e_unf = fpu_unf; e_err = 0; m_resp_at = cyc + 1;
      end else if (cyc == m_acc + 1 + TIMEOUT) begin
        exp_rstn = 0; e_y = '0; e_ovf = 0; e_unf = 0; e_err = 1; m_resp_at = cyc + 1;
      end
    end
    exp_op = (in_fpu && cyc == m_acc + 1) ? (10'd1 << m_op) : '0;
    exp_rv = m_resp ? NREQ'(1 << m_g) : '0;
    g      = m_inflight ? -1 : pick(m_ptr, req_valid);
    exp_rr = (g >= 0) ? NREQ'(1 << g) : '0;
    chk("fpu_rstn", 32'(fpu_rstn), 32'(exp_rstn));
    chk("busy", 32'(busy), 32'(m_inflight));
    chk("fpu_opcode", 32'(fpu_opcode), 32'(exp_op));
    chk("fpu_x1", fpu_x1, in_fpu ? m_x1 : 32'd0);
    chk("fpu_x2", fpu_x2, in_fpu ? m_x2 : 32'd0);
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    if (m_resp) begin
      chk("resp_y", resp_y, e_y);
      chk("resp_ovf", 32'(resp_ovf), 32'(e_ovf));
      chk("resp_unf", 32'(resp_unf), 32'(e_unf));
      chk("resp_err", 32'(resp_err), 32'(e_err));
    end
    if (!fpu_rstn) n_rstn_low++;
    if (log_en && req_ready != '0) rr_log.push_back(req_ready);
    if (m_resp && resp_ready[m_g]) begin
      m_inflight = 0; m_resp = 0; n_hs++; last_y = resp_y; last_err = resp_err;
    end
    if (g >= 0) begin
      m_inflight = 1; m_g = g; m_op = req_op[g]; m_x1 = req_x1[g]; m_x2 = req_x2[g];
      m_acc = cyc; m_ptr = (g + 1) % NREQ;
      if (m_op > 4'd9) begin
        e_y = '0; e_ovf = 0; e_unf = 0; e_err = 1; m_resp_at = cyc + 1;
      end else m_resp_at = -1;
    end
    prev_rstn = fpu_rstn;
  endtask

  // One clock: behavioural FPU, then requester stimulus, then reference check.
  task automatic tick();
    logic fire;
    @(posedge sys_clk); #1;
    cyc++;
    rst  = rst_k;
    fire = 1'b0;
    if (!prev_rstn) fcnt = 0;
    if (fcnt > 0) begin
      fcnt--;
      fire = (fcnt == 0);
    end
    if (stray_now || int'($urandom_range(99)) < p_stray) fire = 1'b1;
    fpu_valid = fire;
    fpu_y     = (fire && fix_y_en) ? fix_y : $urandom;
    fpu_ovf   = 1'($urandom);
    fpu_unf   = 1'($urandom);
    if (fpu_opcode != '0) begin
      n_pulses++;
      fcnt = pick_lat();
    end
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]  = req_mask[i] && (int'($urandom_range(99)) < p_req);
      req_op[i]     = pick_op();
      req_x1[i]     = fix_en ? fix_x1 : $urandom;
      req_x2[i]     = fix_en ? fix_x2 : $urandom;
      resp_ready[i] = int'($urandom_range(99)) < p_rdy;
    end
    #1;
    check();
  endtask

  initial begin
    // reset and reset state
    repeat (3) tick();
    rst_k = 0;
    tick();
    chk("rst_resp_y", resp_y, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_flags", 32'({resp_ovf, resp_unf}), 32'd0);

    // single fadd, FPU answers 3 cycles after the pulse
    req_mask = 2'b01; p_req = 100; op_mode = 2; fix_op = 0; fix_en = 1;
    fix_x1 = 32'h3F800000; fix_x2 = 32'h40000000; fix_y_en = 1; fix_y = 32'h40400000;
    lat_mode = 3; p_rdy = 100;
    tick();
    chk("t1_accept", 32'(req_ready), 32'd1);
    p_req = 0; fix_en = 0; n0 = n_pulses; hs0 = n_hs;
    repeat (6) tick();
    chk("t1_pulses", 32'(n_pulses - n0), 32'd1);
    chk("t1_hs", 32'(n_hs - hs0), 32'd1);
    chk("t1_y", last_y, 32'h40400000);
    chk("t1_err", 32'(last_err), 32'd0);
    fix_y_en = 0;

    // both requesters always valid, fmul: grants alternate starting at 1
    req_mask = 2'b11; p_req = 100; fix_op = 2; lat_mode = -3; log_en = 1;
    rr_log.delete();
    repeat (40) tick();
    log_en = 0; p_req = 0;
    repeat (12) tick();
    chk("t2_ngrants", 32'(rr_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < rr_log.size(); i++)
      chk("t2_alt", 32'(rr_log[i]), (i % 2 == 0) ? 32'd2 : 32'd1);

    // illegal op from requester 1
    req_mask = 2'b10; p_req = 100; fix_op = 12;
    tick();
    chk("t3_accept", 32'(req_ready), 32'd2);
    p_req = 0; n0 = n_pulses; hs0 = n_hs;
    repeat (3) tick();
    chk("t3_pulses", 32'(n_pulses - n0), 32'd0);
    chk("t3_hs", 32'(n_hs - hs0), 32'd1);
    chk("t3_err", 32'(last_err), 32'd1);
    chk("t3_y", last_y, 32'd0);

    // hung FPU: watchdog, then a normal op
    req_mask = 2'b01; p_req = 100; op_mode = 0; lat_mode = -1;
    tick();
    p_req = 0; low0 = n_rstn_low; hs0 = n_hs;
    repeat (70) tick();
    chk("t4_rstn_pulses", 32'(n_rstn_low - low0), 32'd1);
    chk("t4_hs", 32'(n_hs - hs0), 32'd1);
    chk("t4_err", 32'(last_err), 32'd1);
    lat_mode = -3; p_req = 100;
    tick();
    p_req = 0; hs0 = n_hs;
    repeat (10) tick();
    chk("t4_next_hs", 32'(n_hs - hs0), 32'd1);
    chk("t4_next_err", 32'(last_err), 32'd0);

    // response back-pressure with requests pending
    req_mask = 2'b11; p_req = 100; p_rdy = 0; hs0 = n_hs;
    repeat (20) tick();
    chk("t5_no_hs", 32'(n_hs - hs0), 32'd0);
    p_rdy = 100; p_req = 0;
    repeat (12) tick();

    // reset in WAIT, then a stray late fpu_valid
    req_mask = 2'b01; p_req = 100; lat_mode = 20;
    tick();
    p_req = 0; hs0 = n_hs;
    repeat (4) tick();
    rst_k = 1;
    tick();
    rst_k = 0;
    tick();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_resp_valid", 32'(resp_valid), 32'd0);
    chk("t6_fpu_rstn", 32'(fpu_rstn), 32'd0);
    stray_now = 1;
    tick();
    stray_now = 0;
    repeat (4) tick();
    chk("t6_no_resp", 32'(n_hs - hs0), 32'd0);
    req_mask = 2'b11; p_req = 100; lat_mode = -3;
    tick();
    chk("t6_ptr_reset", 32'(req_ready), 32'd1);
    p_req = 0;
    repeat (10) tick();

    // random soak
    p_req = 40; op_mode = 1; lat_mode = -2; p_rdy = 50; p_stray = 3;
    repeat (1500) tick();
    p_req = 0; p_stray = 0; p_rdy = 100;
    repeat (80) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
